// File: rtl/divsu_fx.sv
// Sequential fixed-point divider for signed or unsigned Qm.n operands.
// Uses restoring long division with one guard bit for round-to-nearest,
// and saturates or zeroes the result on overflow and divide-by-zero.
module divsu_fx #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 18,
  parameter bit SATURATE = 1'b1
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             START_I,
  input  logic             SIGNED_I,
  input  logic             ROUND_I,
  input  logic [WIDTH-1:0] DIVIDEND_I,
  input  logic [WIDTH-1:0] DIVISOR_I,
  output logic             BUSY_O,
  output logic             DONE_O,
  output logic             VLD_O,
  output logic             DBZ_O,
  output logic             OVF_O,
  output logic [WIDTH-1:0] QUOTIENT_O
);

  // The quotient carries FBITS result fraction bits plus one guard bit for rounding.
  localparam int N  = WIDTH + FBITS + 1;
  localparam int CW = $clog2(N + 1);

  // Magnitude limits, widened to the quotient width so they compare directly.
  localparam logic [N-1:0] LIM_U  = {{(N-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [N-1:0] LIM_SP = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0] LIM_SN = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic             sgn_reg, sgn_next;
  logic             rnd_reg, rnd_next;
  logic             neg_reg, neg_next;
  logic [N-1:0]     num_reg, num_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [N-1:0]     quo_reg, quo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             vld_reg, vld_next;
  logic             ovf_reg, ovf_next;
  logic             dbz_reg, dbz_next;
  logic [WIDTH-1:0] q_reg, q_next;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [N-1:0]     mag;
  logic [N-1:0]     limit;

  // Saturation value for the requested format and result sign.
  function automatic logic [WIDTH-1:0] clamp_val(input logic sgn_mode, input logic neg);
    if (!sgn_mode)
      return {WIDTH{1'b1}};
    else if (neg)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic sgn_mode, input logic [WIDTH-1:0] x);
    return (sgn_mode && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign rem_shift = {rem_reg, num_reg[N-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_reg};
  assign mag       = {1'b0, quo_reg[N-1:1]} + {{(N-1){1'b0}}, rnd_reg & quo_reg[0]};
  assign limit     = !sgn_reg ? LIM_U : (neg_reg ? LIM_SN : LIM_SP);

  assign BUSY_O     = (state_reg != IDLE);
  assign DONE_O     = done_reg;
  assign VLD_O      = vld_reg;
  assign DBZ_O      = dbz_reg;
  assign OVF_O      = ovf_reg;
  assign QUOTIENT_O = q_reg;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg <= IDLE;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      sgn_reg   <= 1'b0;
      rnd_reg   <= 1'b0;
      neg_reg   <= 1'b0;
      num_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      vld_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      dbz_reg   <= 1'b0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      dvd_reg   <= dvd_next;
      dvs_reg   <= dvs_next;
      sgn_reg   <= sgn_next;
      rnd_reg   <= rnd_next;
      neg_reg   <= neg_next;
      num_reg   <= num_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      vld_reg   <= vld_next;
      ovf_reg   <= ovf_next;
      dbz_reg   <= dbz_next;
      q_reg     <= q_next;
    end
  end

  // Next-state and datapath update: capture, prepare magnitudes, iterate, then fix up.
  always_comb begin
    state_next = state_reg;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    sgn_next   = sgn_reg;
    rnd_next   = rnd_reg;
    neg_next   = neg_reg;
    num_next   = num_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    vld_next   = vld_reg;
    ovf_next   = ovf_reg;
    dbz_next   = dbz_reg;
    q_next     = q_reg;
    case (state_reg)
      IDLE: begin
        if (START_I) begin
          dvd_next = DIVIDEND_I;
          dvs_next = DIVISOR_I;
          sgn_next = SIGNED_I;
          rnd_next = ROUND_I;
          vld_next = 1'b0;
          ovf_next = 1'b0;
          dbz_next = 1'b0;
          if (DIVISOR_I == '0) begin
            // Divide-by-zero is resolved immediately without leaving IDLE.
            dbz_next  = 1'b1;
            done_next = 1'b1;
            q_next    = SATURATE ? clamp_val(SIGNED_I, SIGNED_I & DIVIDEND_I[WIDTH-1]) : '0;
          end else begin
            state_next = PREP;
          end
        end
      end
      PREP: begin
        neg_next   = sgn_reg & (dvd_reg[WIDTH-1] ^ dvs_reg[WIDTH-1]);
        num_next   = {abs_val(sgn_reg, dvd_reg), {(FBITS+1){1'b0}}};
        dvs_next   = abs_val(sgn_reg, dvs_reg);
        rem_next   = '0;
        quo_next   = '0;
        cnt_next   = '0;
        state_next = ITER;
      end
      ITER: begin
        // The remainder stays below the divisor, so WIDTH bits hold it after subtraction.
        if (rem_shift >= {1'b0, dvs_reg}) begin
          rem_next = rem_diff[WIDTH-1:0];
          quo_next = {quo_reg[N-2:0], 1'b1};
        end else begin
          rem_next = rem_shift[WIDTH-1:0];
          quo_next = {quo_reg[N-2:0], 1'b0};
        end
        num_next = num_reg << 1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1))
          state_next = FIX;
      end
      FIX: begin
        if (mag > limit) begin
          ovf_next = 1'b1;
          q_next   = SATURATE ? clamp_val(sgn_reg, neg_reg) : '0;
        end else begin
          vld_next = 1'b1;
          q_next   = neg_reg ? (~mag[WIDTH-1:0] + 1'b1) : mag[WIDTH-1:0];
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
